ysyx_23060332_mem_arb: RTL and testbench

YSYX_23060332_MEM_ARB -- requirements
Module: ysyx_23060332_mem_arb

---
 rtl/ysyx_23060332_mem_arb.sv | 179 +++++++++++++++++
 tb/tb_ysyx_23060332_mem_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_mem_arb
//   Arbitrates a single memory port between the instruction-fetch unit (IFU)
//   and the load/store unit (LSU). At most one transaction is in flight:
//   IDLE grants a requester and latches its fields, REQ presents them to
//   memory until accepted, and WAIT forwards the response to the owner.
//
// Configuration macro:
//   YSYX_23060332_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                            undefined -> LSU has fixed priority over IFU
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ifu_req_valid/ready      fetch request handshake (ready is combinational)
//   ifu_addr                 fetch address
//   ifu_rsp_valid, ifu_rdata fetch response (one-cycle pulse)
//   lsu_req_valid/ready      load/store request handshake
//   lsu_addr/wen/wdata/wmask load/store fields
//   lsu_rsp_valid, lsu_rdata load data or store acknowledge
//   mem_req_valid/ready      request handshake towards memory
//   mem_addr/wen/wdata/wmask request fields, held stable while in REQ
//   mem_rsp_valid, mem_rdata memory response, honoured only in WAIT
// ---------------------------------------------------------------------------
module ysyx_23060332_mem_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner_lsu;   // 1 = LSU owns the transaction, 0 = IFU
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
`ifdef YSYX_23060332_ARB_RR_EN
  logic                r_ptr_lsu;     // 1 = LSU wins the next contested grant
`endif

  logic                w_run;         // high whenever reset is not asserted
  logic                w_idle;
  logic                w_in_req;
  logic                w_rsp_hit;     // a response that completes the transaction
  logic                w_grant_lsu;
  logic                w_grant_ifu;

  assign w_run     = rst;
  assign w_idle    = w_run && (r_state == S_IDLE);
  assign w_in_req  = w_run && (r_state == S_REQ);
  assign w_rsp_hit = w_run && (r_state == S_WAIT) && mem_rsp_valid;

  // Arbitration: only evaluated in IDLE; a request dropped before this cycle
  // is simply not seen.
  always_comb begin
    w_grant_lsu = 1'b0;
    w_grant_ifu = 1'b0;
    if (w_idle) begin
`ifdef YSYX_23060332_ARB_RR_EN
      if (lsu_req_valid && ifu_req_valid) begin
        w_grant_lsu = r_ptr_lsu;
        w_grant_ifu = !r_ptr_lsu;
      end else begin
        w_grant_lsu = lsu_req_valid;
        w_grant_ifu = ifu_req_valid;
      end
`else
      w_grant_lsu = lsu_req_valid;
      w_grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  // Request handshakes are combinational so the grant lands in the same cycle.
  assign lsu_req_ready = w_grant_lsu;
  assign ifu_req_ready = w_grant_ifu;

  // Memory request side: latched fields, forced to zero while in reset.
  assign mem_req_valid = w_in_req;
  assign mem_addr      = w_run ? r_addr  : ADDR_W'(0);
  assign mem_wen       = w_run ? r_wen   : 1'b0;
  assign mem_wdata     = w_run ? r_wdata : DATA_W'(0);
  assign mem_wmask     = w_run ? r_wmask : MASK_W'(0);

  // Response routing: data is shared, the valid goes only to the owner.
  assign lsu_rsp_valid = w_rsp_hit && r_owner_lsu;
  assign ifu_rsp_valid = w_rsp_hit && !r_owner_lsu;
  assign lsu_rdata     = mem_rdata;
  assign ifu_rdata     = mem_rdata;

  // Transaction FSM with latched request fields and owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner_lsu <= 1'b0;
      r_addr      <= ADDR_W'(0);
      r_wen       <= 1'b0;
      r_wdata     <= DATA_W'(0);
      r_wmask     <= MASK_W'(0);
`ifdef YSYX_23060332_ARB_RR_EN
      r_ptr_lsu   <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_lsu) begin
            r_state     <= S_REQ;
            r_owner_lsu <= 1'b1;
            r_addr      <= lsu_addr;
            r_wen       <= lsu_wen;
            r_wdata     <= lsu_wdata;
            r_wmask     <= lsu_wmask;
`ifdef YSYX_23060332_ARB_RR_EN
            r_ptr_lsu   <= 1'b0;
`endif
          end else if (w_grant_ifu) begin
            // Fetches are always reads with no strobes.
            r_state     <= S_REQ;
            r_owner_lsu <= 1'b0;
            r_addr      <= ifu_addr;
            r_wen       <= 1'b0;
            r_wdata     <= DATA_W'(0);
            r_wmask     <= MASK_W'(0);
`ifdef YSYX_23060332_ARB_RR_EN
            r_ptr_lsu   <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060332_mem_arb
//   Directed bench for the IFU/LSU memory arbiter. Inputs change 1 time unit
//   after the rising edge; outputs are sampled 2 time units after it.
// ---------------------------------------------------------------------------
module tb_ysyx_23060332_mem_arb;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  int n_chk;
  int n_err;

  ysyx_23060332_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 unit after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    logic exp_lsu;
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h0;
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h0;
    lsu_wen = 1'b0;
    lsu_wdata = 32'h0;
    lsu_wmask = 4'h0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;

    // Reset: every ready/valid/mem output is low even with inputs active.
    cyc();
    cyc();
    settle();
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("rst_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    chk("rst_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    cyc();
    rst = 1'b1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    settle();
    chk("post_rst_mem_wmask", 64'(mem_wmask), 64'd0);

    // Single fetch: grant N, request N+1, response N+2.
    cyc();
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    settle();
    chk("f_ifu_ready", 64'(ifu_req_ready), 64'd1);
    chk("f_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("f_mem_valid_idle", 64'(mem_req_valid), 64'd0);
    cyc();
    ifu_req_valid = 1'b0;
    ifu_addr = 32'hFFFF_FFFF;
    mem_req_ready = 1'b1;
    settle();
    chk("f_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("f_mem_addr", 64'(mem_addr), 64'h8000_0000);
    chk("f_mem_wen", 64'(mem_wen), 64'd0);
    chk("f_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("f_ifu_ready_req", 64'(ifu_req_ready), 64'd0);
    chk("f_ifu_rsp_early", 64'(ifu_rsp_valid), 64'd0);
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0000_0413;
    settle();
    chk("f_mem_valid_wait", 64'(mem_req_valid), 64'd0);
    chk("f_ifu_rsp", 64'(ifu_rsp_valid), 64'd1);
    chk("f_ifu_rdata", 64'(ifu_rdata), 64'h0000_0413);
    chk("f_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    chk("f_lsu_rdata", 64'(lsu_rdata), 64'h0000_0413);

    // Stray response in IDLE is ignored and does not disturb the FSM.
    cyc();
    mem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("stray_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    chk("stray_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    chk("stray_mem_valid", 64'(mem_req_valid), 64'd0);
    cyc();
    mem_rsp_valid = 1'b0;

    // Store held for three cycles of backpressure; IFU locked out meanwhile.
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b1;
    lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'b0011;
    settle();
    chk("st_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("st_ifu_ready", 64'(ifu_req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      lsu_req_valid = 1'b0;
      lsu_addr = 32'h0;
      lsu_wdata = 32'h0;
      lsu_wmask = 4'h0;
      lsu_wen = 1'b0;
      ifu_req_valid = 1'b1;
      mem_req_ready = (i == 3);
      settle();
      chk("st_mem_valid", 64'(mem_req_valid), 64'd1);
      chk("st_mem_addr", 64'(mem_addr), 64'h8000_1000);
      chk("st_mem_wen", 64'(mem_wen), 64'd1);
      chk("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("st_mem_wmask", 64'(mem_wmask), 64'h3);
      chk("st_ifu_ready_busy", 64'(ifu_req_ready), 64'd0);
    end
    cyc();
    mem_req_ready = 1'b0;
    settle();
    chk("st_wait_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("st_wait_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    chk("st_wait_ifu_ready", 64'(ifu_req_ready), 64'd0);
    cyc();
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    chk("st_lsu_rsp", 64'(lsu_rsp_valid), 64'd1);
    chk("st_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    cyc();
    settle();
    chk("st_lsu_rsp_once", 64'(lsu_rsp_valid), 64'd0);
    cyc();
    mem_rsp_valid = 1'b0;

    // Reset while waiting abandons the fetch; a stale response is dropped.
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0004;
    settle();
    chk("rw_ifu_ready", 64'(ifu_req_ready), 64'd1);
    cyc();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    settle();
    chk("rw_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rw_rst_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    cyc();
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    settle();
    chk("rw_stale_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    chk("rw_stale_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    chk("rw_addr_cleared", 64'(mem_addr), 64'd0);
    cyc();
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0008;
    settle();
    chk("rw_regrant", 64'(ifu_req_ready), 64'd1);
    cyc();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("rw_mem_addr", 64'(mem_addr), 64'h8000_0008);
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0000_0013;
    settle();
    chk("rw_ifu_rsp", 64'(ifu_rsp_valid), 64'd1);
    chk("rw_ifu_rdata", 64'(ifu_rdata), 64'h0000_0013);
    cyc();
    mem_rsp_valid = 1'b0;

    // Fresh reset, then contention with memory always ready/responding.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h0000_0100;
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b0;
    lsu_addr = 32'h0000_0200;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef YSYX_23060332_ARB_RR_EN
      exp_lsu = ((g % 2) == 0);
`else
      exp_lsu = 1'b1;
`endif
      settle();
      chk("c_lsu_ready", 64'(lsu_req_ready), 64'(exp_lsu));
      chk("c_ifu_ready", 64'(ifu_req_ready), 64'(!exp_lsu));
      cyc();
      settle();
      chk("c_mem_addr", 64'(mem_addr), exp_lsu ? 64'h200 : 64'h100);
      chk("c_req_no_rsp", 64'(lsu_rsp_valid | ifu_rsp_valid), 64'd0);
      cyc();
      settle();
      chk("c_lsu_rsp", 64'(lsu_rsp_valid), 64'(exp_lsu));
      chk("c_ifu_rsp", 64'(ifu_rsp_valid), 64'(!exp_lsu));
      cyc();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
